// File: rtl/if_id_queue.sv
// In-order IF/ID instruction queue: DEPTH entries between fetch and decode, head drives decode.
// Latency 1 cycle push-to-head; ReadyF drops when full (no pop-through), flush empties in one cycle.
// Backpressure: a push while full is dropped and latches the sticky OverflowErr flag.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

module if_id_queue #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushD,
  input  logic            PushF,
  output logic            ReadyF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic [31:0]     InstrF,
  input  logic            PopD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [31:0]     InstrD,
  output logic            IFID_valid,
  output logic [CW-1:0]   Count,
  output logic            OverflowErr
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            push_ok;
  logic            pop_ok;

  assign ReadyF      = (count != CW'(DEPTH));
  assign IFID_valid  = (count != '0);
  assign push_ok     = PushF & ReadyF & ~FlushD;
  assign pop_ok      = PopD & IFID_valid & ~FlushD;
  assign Count       = count;
  assign OverflowErr = overflow;

  // Storage is masked by count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{pc: PCF, pc_plus4: PCPlus4F, instr: InstrF};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (PushF & ~ReadyF & ~FlushD) begin
        overflow <= 1'b1;
      end
      if (FlushD) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    PCD      = '0;
    PCPlus4D = '0;
    InstrD   = riscv_pkg::INSTR_NOP;
    if (IFID_valid) begin
      PCD      = mem[rd_ptr].pc;
      PCPlus4D = mem[rd_ptr].pc_plus4;
      InstrD   = mem[rd_ptr].instr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized + directed bench for if_id_queue; a queue-based scoreboard is filled by the
// stimulus process and drained by a negedge monitor that checks head, occupancy and flags.
module tb_if_id_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            FlushD;
  logic            PushF;
  logic            ReadyF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic [31:0]     InstrF;
  logic            PopD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [31:0]     InstrD;
  logic            IFID_valid;
  logic [CW-1:0]   Count;
  logic            OverflowErr;

  if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .FlushD(FlushD), .PushF(PushF), .ReadyF(ReadyF),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .PopD(PopD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD), .IFID_valid(IFID_valid),
    .Count(Count), .OverflowErr(OverflowErr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   mdl_cnt = 0;
  bit   mdl_ovf = 1'b0;
  int   exp_cnt_now = 0;
  bit   exp_ovf_now = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive just after the edge and advance the abstract model,
  // recording what the DUT should show during this cycle.
  task automatic cycle(input bit push, input bit pop, input bit flush,
                       input logic [31:0] pc, input logic [31:0] instr);
    bit pacc;
    bit pacc_pop;
    @(posedge clk);
    #1;
    PushF = push; PopD = pop; FlushD = flush;
    PCF = pc; PCPlus4F = pc + 32'd4; InstrF = instr;
    exp_cnt_now = mdl_cnt;
    exp_ovf_now = mdl_ovf;
    if (flush) begin
      mdl_cnt = 0;
      exp_q.delete();
    end else begin
      pacc     = push && (mdl_cnt < DEPTH);
      pacc_pop = pop && (mdl_cnt > 0);
      if (push && !pacc) mdl_ovf = 1'b1;
      if (pacc) exp_q.push_back('{pc: pc, pc4: pc + 32'd4, instr: instr});
      mdl_cnt = mdl_cnt + int'(pacc) - int'(pacc_pop);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(Count), 32'(exp_cnt_now));
      chk("ready", 32'(ReadyF), 32'(exp_cnt_now != DEPTH));
      chk("valid", 32'(IFID_valid), 32'(exp_cnt_now != 0));
      chk("overflow", 32'(OverflowErr), 32'(exp_ovf_now));
      if (exp_cnt_now == 0) begin
        chk("empty_instr", InstrD, NOP);
        chk("empty_pc", PCD, 32'd0);
        chk("empty_pc4", PCPlus4D, 32'd0);
      end else if (!FlushD) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expected entry for head pc %h", PCD);
        end else begin
          mon_e = exp_q[0];
          chk("head_pc", PCD, mon_e.pc);
          chk("head_pc4", PCPlus4D, mon_e.pc4);
          chk("head_instr", InstrD, mon_e.instr);
          if (PopD) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    rst = 1'b1; FlushD = 0; PushF = 0; PopD = 0;
    PCF = '0; PCPlus4F = '0; InstrF = '0;
    #2;
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_valid", 32'(IFID_valid), 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pc", PCD, 32'd0);
    chk("rst_ready", 32'(ReadyF), 32'd1);
    chk("rst_ovf", 32'(OverflowErr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cycle(0, 0, 0, 32'd0, 32'd0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 32'h100 + 32'(4 * i), $urandom);
    cycle(1, 0, 0, 32'h200, $urandom);
    cycle(0, 0, 0, 32'd0, 32'd0);
    // Drain.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'd0, 32'd0);
    cycle(0, 1, 0, 32'd0, 32'd0);

    // Steady push+pop at occupancy 1 across pointer wrap.
    pc = 32'h400;
    cycle(1, 0, 0, pc, $urandom);
    for (int i = 0; i < 10; i++) begin
      pc = pc + 32'd4;
      cycle(1, 1, 0, pc, $urandom);
    end
    cycle(0, 1, 0, 32'd0, 32'd0);

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h800 + 32'(4 * i), $urandom);
    cycle(1, 1, 1, 32'h900, $urandom);
    cycle(1, 0, 0, 32'hA00, $urandom);
    cycle(0, 0, 0, 32'd0, 32'd0);
    cycle(0, 1, 0, 32'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    // Asynchronous reset mid-cycle with two entries.
    cycle(0, 0, 1, 32'd0, 32'd0);
    cycle(1, 0, 0, 32'hC00, $urandom);
    cycle(1, 0, 0, 32'hC04, $urandom);
    cycle(0, 0, 0, 32'd0, 32'd0);
    #6 rst = 1'b1;
    #1;
    chk("arst_count", 32'(Count), 32'd0);
    chk("arst_valid", 32'(IFID_valid), 32'd0);
    chk("arst_instr", InstrD, NOP);
    chk("arst_pc", PCD, 32'd0);
    chk("arst_ready", 32'(ReadyF), 32'd1);
    chk("arst_ovf", 32'(OverflowErr), 32'd0);
    mdl_cnt = 0; mdl_ovf = 1'b0; exp_q.delete();
    exp_cnt_now = 0; exp_ovf_now = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    repeat (6) cycle(0, 1, 0, 32'd0, 32'd0);
    cycle(0, 0, 0, 32'd0, 32'd0);
    @(posedge clk);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
